rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 18 +
 rtl/rf_wq_fifo.sv | 98 +++++++++
 rtl/rf_write_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_arb_pkg : shared types and sizing for the reg_file write arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int REG_ADDR_W           = 5;
  localparam int XLEN                 = 32;
  localparam int DEPTH_DEFAULT        = 2;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_wq_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_wq_fifo : multi-cycle write queue with per-entry address match. Rev 1.0
// ---------------------------------------------------------------------------
module rf_wq_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  input  logic [REG_ADDR_W-1:0] match_addr_i,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [XLEN-1:0]       head_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  match_o
);

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // The head being popped this cycle is still valid here, so it still matches.
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == match_addr_i)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_write_arbiter : shares the reg_file write port between WB and a queued
//                    multi-cycle unit, with starvation-triggered drain. Rev 1.0
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_addr,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] pend_addr,
  output logic                  pend_hit,
  output logic                  stall_wb,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic                  WE3
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [STV_W-1:0]      starve_q, starve_d;

  logic                  wb_grant, head_grant, head_blocked, enq;
  logic                  fifo_full, fifo_empty, fifo_match;
  logic [CNT_W-1:0]      fifo_count;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;

  assign stall_wb = (state_q == DRAIN);

  // Reset gating keeps the port quiet while reset is held, whatever WB drives.
  assign wb_grant     = !reset && !stall_wb && wb_we && (wb_addr != '0);
  assign head_grant   = !reset && !fifo_empty && !wb_grant;
  assign head_blocked = !fifo_empty && !head_grant;

  assign mc_ready = !reset && (state_q == NORMAL) && !fifo_full;
  assign enq      = mc_valid && mc_ready && (mc_addr != '0);
  assign pend_hit = (pend_addr != '0) && fifo_match;

  rf_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (enq),
    .push_addr_i  (mc_addr),
    .push_data_i  (mc_data),
    .pop_i        (head_grant),
    .match_addr_i (pend_addr),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .match_o      (fifo_match)
  );

  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (wb_grant) begin
      WE3 = 1'b1;
      A3  = wb_addr;
      WD3 = wb_data;
    end else if (head_grant) begin
      WE3 = 1'b1;
      A3  = head_addr;
      WD3 = head_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = head_blocked ? (starve_q + STV_W'(1)) : '0;
    case (state_q)
      NORMAL: begin
        if (head_blocked && (starve_q == STV_W'(STARVE_LIMIT - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty || (head_grant && (fifo_count == CNT_W'(1)))) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule
`default_nettype wire
